// File: rtl/frv_dmem_arb.sv
// Two-requester data-memory arbiter with an in-order response ID FIFO.
// Define FRV_DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module frv_dmem_arb #(
    parameter int OUTSTANDING = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic [1:0]  r_req,
    input  logic [1:0]  r_wen,
    input  logic [7:0]  r_strb,
    input  logic [63:0] r_wdata,
    input  logic [63:0] r_addr,
    output logic [1:0]  r_gnt,
    output logic [1:0]  r_recv,
    input  logic [1:0]  r_ack,
    output logic [31:0] r_rdata,
    output logic        r_error,
    output logic        m_req,
    output logic        m_wen,
    output logic [3:0]  m_strb,
    output logic [31:0] m_wdata,
    output logic [31:0] m_addr,
    input  logic        m_gnt,
    input  logic        m_recv,
    output logic        m_ack,
    input  logic [31:0] m_rdata,
    input  logic        m_error
);

    localparam logic [2:0] FULL_CNT = 3'(OUTSTANDING);
    localparam logic [1:0] LAST_PTR = 2'(OUTSTANDING - 1);

    logic       lock_q, lock_d;
    logic       owner_q, owner_d;
    logic [2:0] count_q, count_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0] id_q, id_d;
`ifdef FRV_DMEM_ARB_RR_EN
    logic       last_q, last_d;
`endif

    logic prio_sel;
    logic sel;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;
    logic resp_vld;

    // Arbitration: a stalled request keeps its owner until memory accepts it.
    always_comb begin
`ifdef FRV_DMEM_ARB_RR_EN
        if (r_req == 2'b11) begin
            prio_sel = ~last_q;
        end else begin
            prio_sel = r_req[1] & ~r_req[0];
        end
`else
        prio_sel = r_req[1] & ~r_req[0];
`endif
        sel   = lock_q ? owner_q : prio_sel;
        full  = (count_q == FULL_CNT);
        empty = (count_q == 3'd0);
    end

    // Request channel mux and grant.
    always_comb begin
        m_req   = r_req[sel] & ~full;
        m_wen   = r_wen[sel];
        m_strb  = sel ? r_strb[7:4]    : r_strb[3:0];
        m_wdata = sel ? r_wdata[63:32] : r_wdata[31:0];
        m_addr  = sel ? r_addr[63:32]  : r_addr[31:0];
        push    = m_req & m_gnt & g_resetn;
        r_gnt   = 2'b00;
        if (push) begin
            r_gnt[sel] = 1'b1;
        end
    end

    // Response routing to the oldest outstanding requester.
    always_comb begin
        head     = id_q[rd_ptr_q];
        resp_vld = ~empty & g_resetn;
        r_recv   = 2'b00;
        if (m_recv && resp_vld) begin
            r_recv[head] = 1'b1;
        end
        m_ack   = resp_vld & r_ack[head];
        pop     = m_recv & m_ack;
        r_rdata = m_rdata;
        r_error = m_error;
    end

    always_comb begin
        lock_d   = m_req & ~m_gnt;
        owner_d  = sel;
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
`ifdef FRV_DMEM_ARB_RR_EN
        last_d   = push ? sel : last_q;
`endif
        if (push) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d       = (wr_ptr_q == LAST_PTR) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            lock_q   <= 1'b0;
            owner_q  <= 1'b0;
            count_q  <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
`ifdef FRV_DMEM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef FRV_DMEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    // ID storage is datapath only; pointers and count qualify it.
    always_ff @(posedge g_clk) begin
        id_q <= id_d;
    end

endmodule

// File: tb/tb_frv_dmem_arb.sv
// Directed plus randomized bench for frv_dmem_arb against a queue-based reference model.
module tb_frv_dmem_arb;

    localparam int OUT = 2;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic [1:0]  r_req, r_wen, r_ack;
    logic [7:0]  r_strb;
    logic [63:0] r_wdata, r_addr;
    logic [1:0]  r_gnt, r_recv;
    logic [31:0] r_rdata;
    logic        r_error;
    logic        m_req, m_wen;
    logic [3:0]  m_strb;
    logic [31:0] m_wdata, m_addr;
    logic        m_gnt, m_recv, m_ack;
    logic [31:0] m_rdata;
    logic        m_error;

    frv_dmem_arb #(.OUTSTANDING(OUT)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .r_req(r_req), .r_wen(r_wen), .r_strb(r_strb), .r_wdata(r_wdata), .r_addr(r_addr),
        .r_gnt(r_gnt), .r_recv(r_recv), .r_ack(r_ack), .r_rdata(r_rdata), .r_error(r_error),
        .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_addr(m_addr),
        .m_gnt(m_gnt), .m_recv(m_recv), .m_ack(m_ack), .m_rdata(m_rdata), .m_error(m_error)
    );

    always #5 g_clk = ~g_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: issue-order queue of requester ids plus the stalled-request owner.
    int   q[$];
    int   last_g = 1;
    bit   own_v = 0;
    int   own = 0;
    bit   started = 0;
    int   e_sel;
    logic e_mreq, e_mack;
    logic [1:0] e_gnt, e_recv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_comb();
        int w;
        if (own_v) w = own;
        else if (r_req == 2'b11) begin
`ifdef FRV_DMEM_ARB_RR_EN
            w = 1 - last_g;
`else
            w = 0;
`endif
        end else if (r_req[1]) w = 1;
        else w = 0;
        e_sel  = w;
        e_mreq = r_req[w] && (q.size() < OUT);
        e_gnt  = 2'b00;
        if (g_resetn && e_mreq && m_gnt) e_gnt = (w == 1) ? 2'b10 : 2'b01;
        e_recv = 2'b00;
        e_mack = 1'b0;
        if (g_resetn && q.size() > 0) begin
            e_mack = r_ack[q[0]];
            if (m_recv) e_recv = (q[0] == 1) ? 2'b10 : 2'b01;
        end
    endfunction

    task automatic settle();
        #1;
        model_comb();
        if (started) begin
            chk("r_gnt", 32'(r_gnt), 32'(e_gnt));
            chk("r_recv", 32'(r_recv), 32'(e_recv));
            chk("m_ack", 32'(m_ack), 32'(e_mack));
            chk("m_req", 32'(m_req), 32'(e_mreq));
            if (e_mreq) begin
                chk("m_addr", m_addr, r_addr[e_sel*32 +: 32]);
                chk("m_wdata", m_wdata, r_wdata[e_sel*32 +: 32]);
                chk("m_strb", 32'(m_strb), 32'(r_strb[e_sel*4 +: 4]));
                chk("m_wen", 32'(m_wen), 32'(r_wen[e_sel]));
            end
            chk("r_rdata", r_rdata, m_rdata);
            chk("r_error", 32'(r_error), 32'(m_error));
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        if (!g_resetn) begin
            q.delete();
            own_v = 0;
            last_g = 1;
            started = 1;
        end else begin
            if (e_gnt != 2'b00) begin
                q.push_back(e_sel);
                last_g = e_sel;
            end
            if (e_recv != 2'b00 && e_mack) void'(q.pop_front());
            own_v = e_mreq && !m_gnt;
            own = e_sel;
        end
        @(negedge g_clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    initial begin
        logic [1:0] granted;
        g_resetn = 1'b0;
        r_req = 2'b00; r_wen = 2'b00; r_ack = 2'b00; r_strb = 8'h0;
        r_wdata = 64'h0; r_addr = 64'h0;
        m_gnt = 1'b0; m_recv = 1'b0; m_rdata = 32'h0; m_error = 1'b0;
        @(negedge g_clk);
        cycle();
        settle();
        chk("rst_gnt", 32'(r_gnt), 32'd0);
        chk("rst_recv", 32'(r_recv), 32'd0);
        chk("rst_mreq", 32'(m_req), 32'd0);
        tick();
        g_resetn = 1'b1;

        // Single LSU transaction, then a response with nothing outstanding.
        r_req = 2'b01; r_addr = {32'h2000, 32'h1000}; r_wen = 2'b01;
        r_strb = 8'hAF; r_wdata = {32'h22222222, 32'h11111111}; m_gnt = 1'b1;
        settle();
        chk("t1_addr", m_addr, 32'h1000);
        chk("t1_gnt", 32'(r_gnt), 32'd1);
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1; r_ack = 2'b01; m_rdata = 32'h12345678;
        settle();
        chk("t1_recv", 32'(r_recv), 32'd1);
        tick();
        settle();
        chk("t1_empty_recv", 32'(r_recv), 32'd0);
        chk("t1_empty_ack", 32'(m_ack), 32'd0);
        tick();

        // Both request continuously with responses streaming back.
        r_req = 2'b11; m_gnt = 1'b1; m_recv = 1'b1; r_ack = 2'b11;
        for (int i = 0; i < 4; i++) begin
            settle();
`ifndef FRV_DMEM_ARB_RR_EN
            chk("t2_fixed_gnt", 32'(r_gnt), 32'd1);
`endif
            tick();
        end
        r_req = 2'b10;
        settle();
        chk("t2_p1_gnt", 32'(r_gnt), 32'd2);
        tick();
        r_req = 2'b00; m_gnt = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        m_recv = 1'b0;

        // Owner lock: port 1 stalls, port 0 arrives, port 1 keeps the bus.
        r_req = 2'b10; m_gnt = 1'b0;
        cycle();
        r_req = 2'b11;
        settle();
        chk("lock_addr", m_addr, 32'h2000);
        tick();
        m_gnt = 1'b1;
        settle();
        chk("lock_gnt", 32'(r_gnt), 32'd2);
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        m_recv = 1'b0;

        // Full FIFO blocks requests until a response retires.
        r_req = 2'b01; m_gnt = 1'b1; r_ack = 2'b01;
        cycle();
        cycle();
        settle();
        chk("t4_full_mreq", 32'(m_req), 32'd0);
        chk("t4_full_gnt", 32'(r_gnt), 32'd0);
        tick();
        m_recv = 1'b1;
        settle();
        chk("t4_pop_mreq", 32'(m_req), 32'd0);
        tick();
        m_recv = 1'b0;
        settle();
        chk("t4_reassert", 32'(m_req), 32'd1);
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        m_recv = 1'b0;

        // Responses return in grant order.
        r_req = 2'b01; m_gnt = 1'b1;
        cycle();
        r_req = 2'b10;
        cycle();
        r_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1; r_ack = 2'b11; m_rdata = 32'hDEADBEEF;
        settle();
        chk("t5_first", 32'(r_recv), 32'd1);
        chk("t5_rdata", r_rdata, 32'hDEADBEEF);
        tick();
        settle();
        chk("t5_second", 32'(r_recv), 32'd2);
        tick();
        m_recv = 1'b0;

        // Reset with transactions in flight drops them.
        r_req = 2'b11; m_gnt = 1'b1;
        cycle();
        cycle();
        g_resetn = 1'b0; r_req = 2'b00;
        cycle();
        g_resetn = 1'b1; m_recv = 1'b1; m_gnt = 1'b0;
        settle();
        chk("rst_drop", 32'(r_recv), 32'd0);
        tick();
        m_recv = 1'b0; r_req = 2'b11; m_gnt = 1'b1;
        settle();
        chk("rst_tie", 32'(r_gnt), 32'd1);
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic; requesters hold payload until granted.
        granted = 2'b11;
        r_req = 2'b00;
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p] || granted[p]) begin
                    r_req[p]          = ($urandom_range(0, 3) != 0);
                    r_wen[p]          = 1'($urandom_range(0, 1));
                    r_strb[p*4 +: 4]  = 4'($urandom());
                    r_wdata[p*32 +: 32] = $urandom();
                    r_addr[p*32 +: 32]  = $urandom();
                end
            end
            m_gnt    = ($urandom_range(0, 2) != 0);
            m_recv   = 1'($urandom_range(0, 1));
            r_ack    = 2'($urandom());
            m_rdata  = $urandom();
            m_error  = 1'($urandom_range(0, 1));
            g_resetn = ($urandom_range(0, 63) != 0);
            cycle();
            granted = e_gnt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
